// File: rtl/arbitro_botoes.sv
// Round-robin arbiter turning debounced button pulses into a valid/ready command stream.
// Optional PERDAS_CNT_EN adds a saturating 8-bit counter of dropped button events.
module arbitro_botoes #(
  parameter int unsigned N_BOTOES = 4,
  parameter int unsigned ID_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] flag_botao,
  input  logic                cmd_ready,
  output logic                cmd_valid,
  output logic [ID_W-1:0]     cmd_id,
  output logic [N_BOTOES-1:0] pendentes
`ifdef PERDAS_CNT_EN
  ,
  output logic [7:0]          perdas
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    OCIOSO = 1'b0,
    OFERTA = 1'b1
  } estado_t;

  estado_t             estado, estado_next;
  logic [ID_W-1:0]     ptr, ptr_next;
  logic [ID_W-1:0]     id_next;
  logic [ID_W-1:0]     cand;
  logic                achou;
  logic                valid_next;
  logic [N_BOTOES-1:0] limpa;
  logic [N_BOTOES-1:0] pend_next;
  logic [N_BOTOES-1:0] perdidos;

  // Grant search, handshake and pending-vector update
  always_comb begin
    estado_next = estado;
    ptr_next    = ptr;
    id_next     = cmd_id;
    limpa       = '0;
    achou       = 1'b0;
    cand        = '0;
    case (estado)
      OCIOSO: begin
        if (|pendentes) begin
          for (int unsigned k = 1; k <= N_BOTOES; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_BOTOES);
            if (!achou && pendentes[cand]) begin
              achou   = 1'b1;
              id_next = cand;
            end
          end
          estado_next = OFERTA;
        end
      end
      OFERTA: begin
        if (cmd_ready) begin
          limpa[cmd_id] = 1'b1;
          ptr_next      = cmd_id;
          estado_next   = OCIOSO;
        end
      end
      default: estado_next = OCIOSO;
    endcase
    valid_next = (estado_next == OFERTA);
    // A pulse on the channel being cleared re-arms it instead of being dropped
    pend_next  = (pendentes & ~limpa) | flag_botao;
    perdidos   = flag_botao & pendentes & ~limpa;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      pendentes <= '0;
      ptr       <= ID_W'(N_BOTOES - 1);
    end else begin
      estado    <= estado_next;
      cmd_valid <= valid_next;
      cmd_id    <= id_next;
      pendentes <= pend_next;
      ptr       <= ptr_next;
    end
  end

`ifdef PERDAS_CNT_EN
  logic [CNT_W-1:0] n_perdidos;
  logic [8:0]       soma;
  logic [7:0]       perdas_next;

  // Saturating add of this edge's drop count
  always_comb begin
    n_perdidos = '0;
    for (int unsigned i = 0; i < N_BOTOES; i++) begin
      n_perdidos = n_perdidos + CNT_W'(perdidos[i]);
    end
    soma        = 9'(perdas) + 9'(n_perdidos);
    perdas_next = soma[8] ? 8'hFF : soma[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perdas <= '0;
    end else begin
      perdas <= perdas_next;
    end
  end
`else
  logic unused_perdidos;
  assign unused_perdidos = |{perdidos, CNT_W'(0)};
`endif

endmodule

// File: tb/tb_arbitro_botoes.sv
// Directed self-checking bench for arbitro_botoes (perdas checks when PERDAS_CNT_EN is defined).
module tb_arbitro_botoes;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flag_botao;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic [3:0] pendentes;
`ifdef PERDAS_CNT_EN
  logic [7:0] perdas;
`endif

  int checks   = 0;
  int failures = 0;

  arbitro_botoes #(.N_BOTOES(4), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_botao (flag_botao),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_id     (cmd_id),
    .pendentes  (pendentes)
`ifdef PERDAS_CNT_EN
    ,
    .perdas     (perdas)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flag_botao = '0; cmd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_id",    32'(cmd_id),    0);
    check("rst_pend",  32'(pendentes), 0);
`ifdef PERDAS_CNT_EN
    check("rst_perdas", 32'(perdas), 0);
`endif

    // cmd_ready in idle with nothing pending does nothing
    cmd_ready = 1'b1;
    tick();
    check("idle_ready_valid", 32'(cmd_valid), 0);

    // Single pulse on ch2: offer after E1, cleared after E2
    flag_botao = 4'b0100;
    tick();
    flag_botao = '0;
    check("e0_pend",  32'(pendentes), 32'h4);
    check("e0_valid", 32'(cmd_valid), 0);
    tick();
    check("e1_valid", 32'(cmd_valid), 1);
    check("e1_id",    32'(cmd_id),    2);
    tick();
    check("e2_valid", 32'(cmd_valid), 0);
    check("e2_pend",  32'(pendentes), 0);
    check("e2_id_hold", 32'(cmd_id), 2);

    // All four at once after reset: order 0,1,2,3 with idle cycle between
    do_reset();
    cmd_ready = 1'b1;
    flag_botao = 4'b1111;
    tick();
    flag_botao = '0;
    check("all_pend", 32'(pendentes), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr_valid%0d", k), 32'(cmd_valid), 1);
      check($sformatf("rr_id%0d", k),    32'(cmd_id),    32'(k));
      tick();
      check($sformatf("rr_gap%0d", k),  32'(cmd_valid), 0);
      check($sformatf("rr_pend%0d", k), 32'(pendentes), 32'((4'hF << (k + 1)) & 4'hF));
    end

    // ch1+ch3 with ptr=3: order 1 then 3
    flag_botao = 4'b1010;
    tick();
    flag_botao = '0;
    tick();
    check("p13_id_a", 32'(cmd_id), 1);
    tick();
    tick();
    check("p13_valid_b", 32'(cmd_valid), 1);
    check("p13_id_b",    32'(cmd_id),    3);
    tick();
    check("p13_pend_end", 32'(pendentes), 0);

    // ch1 held 10 cycles with cmd_ready low; second pulse dropped
    cmd_ready = 1'b0;
    flag_botao = 4'b0010;
    tick();
    flag_botao = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      if (c == 3) flag_botao = 4'b0010;
      tick();
      flag_botao = '0;
      check($sformatf("hold_valid%0d", c), 32'(cmd_valid), 1);
      check($sformatf("hold_id%0d", c),    32'(cmd_id),    1);
    end
    check("hold_pend", 32'(pendentes), 32'h2);
`ifdef PERDAS_CNT_EN
    check("hold_perdas", 32'(perdas), 1);
`endif

    // Pulse on the handshake edge of ch1 re-arms ch1
    cmd_ready = 1'b1;
    flag_botao = 4'b0010;
    tick();
    flag_botao = '0;
    check("hs_pulse_valid", 32'(cmd_valid), 0);
    check("hs_pulse_pend",  32'(pendentes), 32'h2);
`ifdef PERDAS_CNT_EN
    check("hs_pulse_perdas", 32'(perdas), 1);
`endif
    tick();
    check("reoffer_valid", 32'(cmd_valid), 1);
    check("reoffer_id",    32'(cmd_id),    1);
    tick();
    check("reoffer_done", 32'(pendentes), 0);

    // 300 edges of overlapping pulses while an offer is held
    cmd_ready = 1'b0;
    flag_botao = 4'b1111;
    for (int c = 0; c < 300; c++) tick();
    check("sat_valid", 32'(cmd_valid), 1);
    check("sat_pend",  32'(pendentes), 32'hF);
`ifdef PERDAS_CNT_EN
    check("sat_perdas", 32'(perdas), 32'hFF);
`endif

    // Reset during an offer overrides handshake and pulses
    rst = 1'b1;
    cmd_ready = 1'b1;
    tick();
    check("rst_offer_valid", 32'(cmd_valid), 0);
    check("rst_offer_pend",  32'(pendentes), 0);
    check("rst_offer_id",    32'(cmd_id),    0);
`ifdef PERDAS_CNT_EN
    check("rst_offer_perdas", 32'(perdas), 0);
`endif
    rst = 1'b0;
    flag_botao = '0;
    cmd_ready = 1'b0;

    // After reset, ptr=3 so ch0 wins over ch2
    flag_botao = 4'b0101;
    tick();
    flag_botao = '0;
    tick();
    check("post_rst_id", 32'(cmd_id), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
